time_of_day_counter: RTL and testbench
======================================

TIME_OF_DAY_COUNTER -- requirements
Module: time_of_day_counter

Interface
REQ-001 Parameter: TICKS_PER_SEC, default 1, Tick pulses per second advance (legal 1..1024).
REQ-002 Clk  input  1  clock; all state changes on posedge Clk.
REQ-003 Clr  input  1  reset; asynchronous, active-low.
REQ-004 Tick  input  1  timebase enable; single-Clk-cycle pulse.
REQ-005 LD  input  1  synchronous load of hours/minutes.
REQ-006 IN_HR_T  input  2  load value, hours tens (BCD).
REQ-007 IN_HR_U  input  4  load value, hours units (BCD).
REQ-008 IN_MIN_T  input  3  load value, minutes tens (BCD).
REQ-009 IN_MIN_U  input  4  load value, minutes units (BCD).
REQ-010 Set_En  input  1  manual set mode; freezes timekeeping.
REQ-011 Set_Sel  input  2  field select: 00 sec, 01 min, 10 hr, 11 none.
REQ-012 Set_Inc  input  1  single-cycle pulse; increments selected field.
REQ-013 HR_T/HR_U, MIN_T/MIN_U, SEC_T/SEC_U  output  2/4, 3/4, 3/4  current time, BCD, registered.
REQ-014 Min_Carry  output  1  one-cycle pulse on minutes-field rollover 59->00 from timekeeping.
REQ-015 Day_Carry  output  1  one-cycle pulse on 23:59:59->00:00:00 from timekeeping; drives Up/Enable of day-of-week counter.
REQ-016 Ld_Err  output  1  one-cycle pulse on rejected load.

Function
REQ-017 Per-edge priority: LD > Set_En > Tick; one action per cycle.
REQ-018 Prescaler: 10-bit count 0..TICKS_PER_SEC-1; Tick with prescaler = TICKS_PER_SEC-1 -> prescaler 0, seconds advance; otherwise prescaler +1, time unchanged.
REQ-019 Seconds advance: units 9->0 carries to tens; 59->00 carries into minutes, same edge.
REQ-020 Minutes: same BCD rule; 59->00 carries into hours, same edge.
REQ-021 Hours: 09->10, 19->20, 23->00; never 24..29.
REQ-022 Time outputs update on the posedge that samples the advancing Tick (zero-cycle latency).
REQ-023 Min_Carry/Day_Carry registered: high exactly during the cycle after the edge producing the rollover; low otherwise; low for LD and Set_Inc wraps.
REQ-024 LD legal (HR<=23, MIN<=59, each units<=9): hours/minutes loaded, seconds -> 00, prescaler -> 0, no carry pulse.
REQ-025 LD illegal: all state unchanged, Ld_Err high next cycle for one cycle; Tick that cycle discarded.
REQ-026 Set_En high: Tick ignored, prescaler held.
REQ-027 Set_En and Set_Inc: selected field +1, wrap within field only (sec 59->00, min 59->00, hr 23->00), no carry to other fields, no carry pulses; Set_Sel=11 no effect.
REQ-028 Set_Inc with Set_En low: ignored.
REQ-029 Set_En falling: prescaler restarts at held value; no catch-up of discarded Ticks.
REQ-030 Tick held high several cycles: each high cycle counts as one Tick.

Reset
REQ-031 Clr low: immediately, independent of Clk: time 00:00:00, prescaler 0, Min_Carry 0, Day_Carry 0, Ld_Err 0.
REQ-032 Clr low mid-operation (pending carry, set mode, load): all discarded, no pulse after release.
REQ-033 First posedge after Clr rises: normal operation; Tick same edge honoured.

Verification
REQ-034 TICKS_PER_SEC=1, LD 23:59, then 1 Tick -> 23:59:01; 58 more Ticks -> 23:59:59; next Tick -> 00:00:00, Min_Carry and Day_Carry high one cycle.
REQ-035 TICKS_PER_SEC=4, from 00:00:00, 4 Ticks -> 00:00:01 after 4th; 3 Ticks -> unchanged.
REQ-036 LD 24:00 or 12:60 or 0A:00 -> time unchanged, Ld_Err one-cycle pulse; LD 12:34 -> 12:34:00, Ld_Err low.
REQ-037 Set_En=1, Set_Sel=10, from 23:59:59 one Set_Inc -> 00:59:59, no Day_Carry; concurrent Ticks ignored.
REQ-038 LD and Tick same cycle at 09:59 -> 09:59:00 (load wins), no Min_Carry.
REQ-039 Clr low while Day_Carry pending at 23:59:59 Tick edge -> 00:00:00, Day_Carry stays 0 after release.

Source files
------------

// File: rtl/time_of_day_counter_if.sv
// Time-of-day counter bus: load, set and timebase controls in,
// BCD time and carry/error pulses out.
interface time_of_day_counter_if;
    logic       Tick;
    logic       LD;
    logic [1:0] IN_HR_T;
    logic [3:0] IN_HR_U;
    logic [2:0] IN_MIN_T;
    logic [3:0] IN_MIN_U;
    logic       Set_En;
    logic [1:0] Set_Sel;
    logic       Set_Inc;
    logic [1:0] HR_T;
    logic [3:0] HR_U;
    logic [2:0] MIN_T;
    logic [3:0] MIN_U;
    logic [2:0] SEC_T;
    logic [3:0] SEC_U;
    logic       Min_Carry;
    logic       Day_Carry;
    logic       Ld_Err;

    modport master (
        output Tick, LD, IN_HR_T, IN_HR_U, IN_MIN_T, IN_MIN_U,
        output Set_En, Set_Sel, Set_Inc,
        input  HR_T, HR_U, MIN_T, MIN_U, SEC_T, SEC_U,
        input  Min_Carry, Day_Carry, Ld_Err
    );

    modport slave (
        input  Tick, LD, IN_HR_T, IN_HR_U, IN_MIN_T, IN_MIN_U,
        input  Set_En, Set_Sel, Set_Inc,
        output HR_T, HR_U, MIN_T, MIN_U, SEC_T, SEC_U,
        output Min_Carry, Day_Carry, Ld_Err
    );
endinterface

// File: rtl/time_of_day_counter.sv
// BCD 24h time-of-day counter with Tick prescaler, load and manual set.
// Ports: Clk, Clr (async active-low), bus (slave: controls in, time/pulses out).
module time_of_day_counter #(
    parameter int TICKS_PER_SEC = 1
) (
    input logic                  Clk,
    input logic                  Clr,
    time_of_day_counter_if.slave bus
);
    localparam logic [9:0] PMAX = 10'(TICKS_PER_SEC - 1);

    logic [1:0] hr_t_q, hr_t_d;
    logic [3:0] hr_u_q, hr_u_d;
    logic [2:0] min_t_q, min_t_d;
    logic [3:0] min_u_q, min_u_d;
    logic [2:0] sec_t_q, sec_t_d;
    logic [3:0] sec_u_q, sec_u_d;
    logic [9:0] pre_q, pre_d;
    logic       mc_q, mc_d;
    logic       dc_q, dc_d;
    logic       le_q, le_d;

    logic sec59, min59, hr23, ld_ok;
    logic do_ld, do_set, do_tick;

    function automatic logic [6:0] inc60(input logic [2:0] t,
                                         input logic [3:0] u);
        if (u == 4'd9)
            inc60 = (t == 3'd5) ? 7'd0 : {t + 3'd1, 4'd0};
        else
            inc60 = {t, u + 4'd1};
    endfunction

    function automatic logic [5:0] inc24(input logic [1:0] t,
                                         input logic [3:0] u);
        if (t == 2'd2 && u == 4'd3)
            inc24 = 6'd0;
        else if (u == 4'd9)
            inc24 = {t + 2'd1, 4'd0};
        else
            inc24 = {t, u + 4'd1};
    endfunction

    assign sec59 = (sec_t_q == 3'd5) && (sec_u_q == 4'd9);
    assign min59 = (min_t_q == 3'd5) && (min_u_q == 4'd9);
    assign hr23  = (hr_t_q == 2'd2) && (hr_u_q == 4'd3);

    assign ld_ok = (bus.IN_HR_T <= 2'd2) && (bus.IN_HR_U <= 4'd9)
                && !(bus.IN_HR_T == 2'd2 && bus.IN_HR_U > 4'd3)
                && (bus.IN_MIN_T <= 3'd5) && (bus.IN_MIN_U <= 4'd9);

    assign do_ld   = bus.LD;
    assign do_set  = !bus.LD && bus.Set_En;
    assign do_tick = !bus.LD && !bus.Set_En && bus.Tick;

    always_comb begin
        hr_t_d  = hr_t_q;
        hr_u_d  = hr_u_q;
        min_t_d = min_t_q;
        min_u_d = min_u_q;
        sec_t_d = sec_t_q;
        sec_u_d = sec_u_q;
        pre_d   = pre_q;
        mc_d    = 1'b0;
        dc_d    = 1'b0;
        le_d    = 1'b0;
        unique case (1'b1)
            do_ld: begin
                if (ld_ok) begin
                    hr_t_d  = bus.IN_HR_T;
                    hr_u_d  = bus.IN_HR_U;
                    min_t_d = bus.IN_MIN_T;
                    min_u_d = bus.IN_MIN_U;
                    sec_t_d = 3'd0;
                    sec_u_d = 4'd0;
                    pre_d   = 10'd0;
                end else begin
                    le_d = 1'b1;
                end
            end
            do_set: begin
                // Manual set wraps inside the field only; prescaler frozen.
                if (bus.Set_Inc) begin
                    unique case (bus.Set_Sel)
                        2'b00: {sec_t_d, sec_u_d} = inc60(sec_t_q, sec_u_q);
                        2'b01: {min_t_d, min_u_d} = inc60(min_t_q, min_u_q);
                        2'b10: {hr_t_d, hr_u_d} = inc24(hr_t_q, hr_u_q);
                        default: ;
                    endcase
                end
            end
            do_tick: begin
                if (pre_q == PMAX) begin
                    pre_d = 10'd0;
                    {sec_t_d, sec_u_d} = inc60(sec_t_q, sec_u_q);
                    if (sec59) begin
                        {min_t_d, min_u_d} = inc60(min_t_q, min_u_q);
                        if (min59) begin
                            {hr_t_d, hr_u_d} = inc24(hr_t_q, hr_u_q);
                            mc_d = 1'b1;
                            dc_d = hr23;
                        end
                    end
                end else begin
                    pre_d = pre_q + 10'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            hr_t_q  <= '0;
            hr_u_q  <= '0;
            min_t_q <= '0;
            min_u_q <= '0;
            sec_t_q <= '0;
            sec_u_q <= '0;
            pre_q   <= '0;
            mc_q    <= 1'b0;
            dc_q    <= 1'b0;
            le_q    <= 1'b0;
        end else begin
            hr_t_q  <= hr_t_d;
            hr_u_q  <= hr_u_d;
            min_t_q <= min_t_d;
            min_u_q <= min_u_d;
            sec_t_q <= sec_t_d;
            sec_u_q <= sec_u_d;
            pre_q   <= pre_d;
            mc_q    <= mc_d;
            dc_q    <= dc_d;
            le_q    <= le_d;
        end
    end

    assign bus.HR_T      = hr_t_q;
    assign bus.HR_U      = hr_u_q;
    assign bus.MIN_T     = min_t_q;
    assign bus.MIN_U     = min_u_q;
    assign bus.SEC_T     = sec_t_q;
    assign bus.SEC_U     = sec_u_q;
    assign bus.Min_Carry = mc_q;
    assign bus.Day_Carry = dc_q;
    assign bus.Ld_Err    = le_q;
endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: two instances (1 and 4 ticks/sec)
// checked every cycle against a seconds-of-day model, plus directed pins.
module tb_time_of_day_counter;
    logic       Clk = 1'b0;
    logic       Clr = 1'b0;
    logic       tick = 0, ld = 0, sen = 0, sinc = 0;
    logic [1:0] hrt = 0, ssel = 0;
    logic [3:0] hru = 0, minu = 0;
    logic [2:0] mint = 0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    time_of_day_counter_if a1();
    time_of_day_counter_if a4();

    assign a1.Tick = tick;     assign a4.Tick = tick;
    assign a1.LD = ld;         assign a4.LD = ld;
    assign a1.IN_HR_T = hrt;   assign a4.IN_HR_T = hrt;
    assign a1.IN_HR_U = hru;   assign a4.IN_HR_U = hru;
    assign a1.IN_MIN_T = mint; assign a4.IN_MIN_T = mint;
    assign a1.IN_MIN_U = minu; assign a4.IN_MIN_U = minu;
    assign a1.Set_En = sen;    assign a4.Set_En = sen;
    assign a1.Set_Sel = ssel;  assign a4.Set_Sel = ssel;
    assign a1.Set_Inc = sinc;  assign a4.Set_Inc = sinc;

    time_of_day_counter #(.TICKS_PER_SEC(1)) u1 (
        .Clk(Clk), .Clr(Clr), .bus(a1)
    );
    time_of_day_counter #(.TICKS_PER_SEC(4)) u4 (
        .Clk(Clk), .Clr(Clr), .bus(a4)
    );

    // Model: time as seconds-of-day, prescaler as an integer.
    int tps [2] = '{1, 4};
    int tod [2];
    int pre [2];
    bit mc [2], dc [2], le [2];

    always @(posedge Clk or negedge Clr) begin
        for (int k = 0; k < 2; k++) begin
            if (!Clr) begin
                tod[k] = 0; pre[k] = 0;
                mc[k] = 0; dc[k] = 0; le[k] = 0;
            end else begin
                int h, m, s;
                mc[k] = 0; dc[k] = 0; le[k] = 0;
                h = tod[k] / 3600; m = (tod[k] / 60) % 60; s = tod[k] % 60;
                if (ld) begin
                    if (hru <= 9 && minu <= 9 && mint <= 5
                        && int'(hrt) * 10 + int'(hru) <= 23) begin
                        tod[k] = (int'(hrt) * 10 + int'(hru)) * 3600
                               + (int'(mint) * 10 + int'(minu)) * 60;
                        pre[k] = 0;
                    end else begin
                        le[k] = 1;
                    end
                end else if (sen) begin
                    if (sinc) begin
                        case (ssel)
                            2'd0: s = (s + 1) % 60;
                            2'd1: m = (m + 1) % 60;
                            2'd2: h = (h + 1) % 24;
                            default: ;
                        endcase
                        tod[k] = h * 3600 + m * 60 + s;
                    end
                end else if (tick) begin
                    if (pre[k] == tps[k] - 1) begin
                        pre[k] = 0;
                        tod[k] = (tod[k] + 1) % 86400;
                        mc[k] = (tod[k] % 3600) == 0;
                        dc[k] = tod[k] == 0;
                    end else begin
                        pre[k] = pre[k] + 1;
                    end
                end
            end
        end
    end

    function automatic logic [22:0] mexp(int k);
        int h, m, s;
        h = tod[k] / 3600; m = (tod[k] / 60) % 60; s = tod[k] % 60;
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
                3'(s / 10), 4'(s % 10), mc[k], dc[k], le[k]};
    endfunction

    function automatic logic [22:0] got(int k);
        if (k == 0)
            return {a1.HR_T, a1.HR_U, a1.MIN_T, a1.MIN_U, a1.SEC_T,
                    a1.SEC_U, a1.Min_Carry, a1.Day_Carry, a1.Ld_Err};
        return {a4.HR_T, a4.HR_U, a4.MIN_T, a4.MIN_U, a4.SEC_T,
                a4.SEC_U, a4.Min_Carry, a4.Day_Carry, a4.Ld_Err};
    endfunction

    always @(negedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [22:0] g, e;
            g = got(k);
            e = mexp(k);
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL model_dut%0d t=%0t got=%h exp=%h",
                         tps[k], $time, g, e);
            end
        end
    end

    // Time as readable hex, e.g. 24'h235901 for 23:59:01.
    function automatic logic [23:0] hms(int k);
        logic [22:0] g;
        g = got(k);
        return {2'b0, g[22:21], g[20:17], 1'b0, g[16:14], g[13:10],
                1'b0, g[9:7], g[6:3]};
    endfunction

    task automatic chk(string nm, logic [23:0] g, logic [23:0] e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, g, e);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        tick = 0; ld = 0; sen = 0; sinc = 0; ssel = 2'd3;
    endtask

    task automatic do_reset();
        idle();
        Clr = 0;
        #7;
        Clr = 1;
        step();
    endtask

    task automatic load(logic [1:0] a, logic [3:0] b,
                        logic [2:0] c, logic [3:0] d);
        ld = 1; hrt = a; hru = b; mint = c; minu = d;
        step();
        idle();
    endtask

    task automatic ticks(int n);
        tick = 1;
        repeat (n) step();
        tick = 0;
    endtask

    initial begin
        idle();
        #3;
        chk("reset_time", hms(0), 24'h000000);
        chk("reset_pulses", 24'(got(0) & 23'h7), 24'h0);
        Clr = 1;
        step();

        // Midnight rollover with 1 tick/sec.
        load(2'd2, 4'd3, 3'd5, 4'd9);
        ticks(1);
        chk("ld_2359_tick1", hms(0), 24'h235901);
        ticks(58);
        chk("to_235959", hms(0), 24'h235959);
        ticks(1);
        chk("midnight", hms(0), 24'h000000);
        chk("midnight_mc", 24'(a1.Min_Carry), 24'h1);
        chk("midnight_dc", 24'(a1.Day_Carry), 24'h1);
        step();
        chk("mc_one_cycle", 24'(a1.Min_Carry), 24'h0);

        // Prescaler of 4.
        do_reset();
        ticks(3);
        chk("tps4_3ticks", hms(1), 24'h000000);
        ticks(1);
        chk("tps4_4ticks", hms(1), 24'h000001);

        // Rejected and accepted loads.
        load(2'd2, 4'd4, 3'd0, 4'd0);
        chk("ld_24_err", 24'(a1.Ld_Err), 24'h1);
        chk("ld_24_time", hms(1), 24'h000001);
        load(2'd1, 4'd2, 3'd6, 4'd0);
        chk("ld_1260_err", 24'(a1.Ld_Err), 24'h1);
        load(2'd0, 4'd10, 3'd0, 4'd0);
        chk("ld_0A_err", 24'(a4.Ld_Err), 24'h1);
        load(2'd1, 4'd2, 3'd3, 4'd4);
        chk("ld_1234", hms(0), 24'h123400);
        chk("ld_1234_noerr", 24'(a1.Ld_Err), 24'h0);

        // Hour set from 23:59:59 with ticks present.
        load(2'd2, 4'd3, 3'd5, 4'd9);
        ticks(59);
        sen = 1; ssel = 2'd2; sinc = 1; tick = 1;
        step();
        idle();
        chk("set_hr", hms(0), 24'h005959);
        chk("set_hr_nodc", 24'(a1.Day_Carry), 24'h0);
        sen = 1; tick = 1;
        step();
        idle();
        chk("set_tick_ign", hms(0), 24'h005959);

        // Load beats tick.
        load(2'd0, 4'd9, 3'd5, 4'd9);
        ticks(59);
        tick = 1;
        load(2'd0, 4'd9, 3'd5, 4'd9);
        chk("ld_wins", hms(0), 24'h095900);
        chk("ld_wins_nomc", 24'(a1.Min_Carry), 24'h0);

        // Reset while Day_Carry pending.
        load(2'd2, 4'd3, 3'd5, 4'd9);
        ticks(59);
        tick = 1;
        step();
        tick = 0;
        Clr = 0;
        #1;
        chk("clr_time", hms(0), 24'h000000);
        chk("clr_dc", 24'(a1.Day_Carry), 24'h0);
        #1;
        Clr = 1;
        step();
        chk("clr_dc_after", 24'(a1.Day_Carry), 24'h0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            tick = 1'($urandom);
            ld = r < 6;
            if ($urandom_range(0, 1) == 1) begin
                hrt = 2'd2; hru = 4'd3;
                mint = 3'd5; minu = 4'($urandom_range(8, 9));
            end else begin
                hrt = 2'($urandom); hru = 4'($urandom);
                mint = 3'($urandom); minu = 4'($urandom);
            end
            if ($urandom_range(0, 19) == 0)
                sen = ~sen;
            ssel = 2'($urandom);
            sinc = 1'($urandom);
            if (r == 99) begin
                #2;
                Clr = 0;
                #2;
                Clr = 1;
            end
            step();
        end
        idle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
